selftrigger_record_capture: RTL



---
 rtl/selftrigger_record_capture.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/selftrigger_record_capture.sv
// Record capture behind the self-trigger filter: rolling pre-trigger history in a
// ring RAM, fixed-length capture around each accepted trigger, header+samples readout.
module selftrigger_record_capture #(
  parameter int PRETRIG  = 64,
  parameter int POSTTRIG = 192,
  parameter int ADDR_W   = 9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic signed [15:0] i_din,
  input  logic signed [15:0] i_baseline,
  input  logic               i_trigger,
  input  logic [63:0]        i_timestamp,
  output logic [15:0]        o_dout,
  output logic               o_dout_valid,
  output logic               o_dout_last,
  input  logic               i_dout_ready,
  output logic               o_busy,
  output logic [15:0]        o_dropped_count
);

  localparam int RECORD_LEN = PRETRIG + POSTTRIG;
  localparam int TOTAL      = RECORD_LEN + 6;
  localparam int FILL_W     = $clog2(PRETRIG + 1);
  localparam int POST_W     = $clog2(POSTTRIG + 1);
  localparam int IDX_W      = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_trig_prev;
  logic [FILL_W-1:0]   r_fill;
  logic [POST_W-1:0]   r_post;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W-1:0]   r_raddr;
  logic [IDX_W-1:0]    r_idx;
  logic [63:0]         r_ts;
  logic [15:0]         r_base;
  logic [15:0]         r_rdata;
  logic [15:0]         r_mem [0:(2**ADDR_W)-1];
  logic                w_trig_evt;
  logic                w_accept;
  logic                w_wr_en;
  logic                w_load;
  logic                w_smp;
  logic                w_done;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [15:0]         w_word;

  assign w_trig_evt = i_trigger && !r_trig_prev;
  assign w_accept   = w_trig_evt && i_enable && (r_state == ST_IDLE);
  assign w_wr_en    = i_enable && (r_state != ST_READOUT);
  assign w_smp      = (r_idx >= IDX_W'(6));
  assign w_load     = (r_state == ST_READOUT) && (r_idx < IDX_W'(TOTAL)) &&
                      (!o_dout_valid || i_dout_ready);
  assign w_done     = (r_state == ST_READOUT) && o_dout_valid && i_dout_ready && o_dout_last;
  // Read address runs one ahead when a sample is consumed, hiding the RAM latency.
  assign w_rd_addr  = (w_load && w_smp) ? (r_raddr + ADDR_W'(1)) : r_raddr;
  assign o_busy     = (r_state == ST_CAPTURE) || (r_state == ST_READOUT);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_ARM;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARM: begin
        if (i_enable && (r_fill == FILL_W'(PRETRIG - 1))) w_state_nxt = ST_IDLE;
        else                                             w_state_nxt = ST_ARM;
      end
      ST_IDLE: begin
        if (!i_enable)       w_state_nxt = ST_ARM;
        else if (w_trig_evt) w_state_nxt = ST_CAPTURE;
        else                 w_state_nxt = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (!i_enable)                     w_state_nxt = ST_ARM;
        else if (r_post == POST_W'(1))     w_state_nxt = ST_READOUT;
        else                               w_state_nxt = ST_CAPTURE;
      end
      ST_READOUT: begin
        if (w_done) w_state_nxt = ST_ARM;
        else        w_state_nxt = ST_READOUT;
      end
      default: w_state_nxt = ST_ARM;
    endcase
  end

  always_comb begin
    w_word = r_rdata;
    case (r_idx)
      IDX_W'(0): w_word = 16'hD5AA;
      IDX_W'(1): w_word = r_ts[63:48];
      IDX_W'(2): w_word = r_ts[47:32];
      IDX_W'(3): w_word = r_ts[31:16];
      IDX_W'(4): w_word = r_ts[15:0];
      IDX_W'(5): w_word = r_base;
      default:   w_word = r_rdata;
    endcase
  end

  // Ring buffer has no reset: contents are only read after a full refill.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wptr] <= i_din;
    r_rdata <= r_mem[w_rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_trig_prev <= 1'b0;
      r_wptr      <= '0;
      r_fill      <= '0;
    end else begin
      r_trig_prev <= i_trigger;
      if (w_wr_en) r_wptr <= r_wptr + ADDR_W'(1);
      r_fill <= (r_state == ST_ARM && i_enable) ? (r_fill + FILL_W'(1)) : FILL_W'(0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ts    <= 64'd0;
      r_base  <= 16'd0;
      r_post  <= '0;
      r_idx   <= '0;
      r_raddr <= '0;
    end else if (w_accept) begin
      r_ts    <= i_timestamp;
      r_base  <= i_baseline;
      r_post  <= POST_W'(POSTTRIG - 1);
      r_idx   <= '0;
      r_raddr <= r_wptr - ADDR_W'(PRETRIG);
    end else begin
      if (r_state == ST_CAPTURE && i_enable) r_post <= r_post - POST_W'(1);
      if (w_load) r_idx <= r_idx + IDX_W'(1);
      if (w_load && w_smp) r_raddr <= r_raddr + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dout       <= 16'd0;
      o_dout_valid <= 1'b0;
      o_dout_last  <= 1'b0;
    end else if (w_load) begin
      o_dout       <= w_word;
      o_dout_valid <= 1'b1;
      o_dout_last  <= (r_idx == IDX_W'(TOTAL - 1));
    end else if (o_dout_valid && i_dout_ready) begin
      o_dout_valid <= 1'b0;
      o_dout_last  <= 1'b0;
    end else begin
      o_dout_valid <= o_dout_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                                       o_dropped_count <= 16'd0;
    else if (w_trig_evt && !w_accept && o_dropped_count != 16'hFFFF)
                                                       o_dropped_count <= o_dropped_count + 16'd1;
    else                                               o_dropped_count <= o_dropped_count;
  end

endmodule
